ace_instbuf: RTL and testbench

Decode-stage-0 instruction buffer. It sits directly downstream of the fetch unit and absorbs the registered 8-wide fetch bundle (`inst0..7_d0` plus their valid bits), compacting the valid slots into a circular FIFO. It presents up to `DEQ_W` oldest instructions per cycle to decode and drives the `decode_instbuf_full` back-pressure that gates the fetch pipeline fill. A retire flush empties it.

---
 rtl/ace_fetch_pkg.sv | 33 +++
 rtl/ace_instbuf_if.sv | 57 +++++
 rtl/ace_instbuf_pack.sv | 21 ++
 rtl/ace_instbuf.sv | 128 ++++++++++++
 tb/tb_ace_instbuf.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ace_fetch_pkg.sv
// Shared fetch/decode types: bundle geometry, the fetch bundle struct and
// the popcount/prefix-count helpers used to compact a fetch bundle.
package ace_fetch_pkg;

  localparam int FETCH_W = 8;
  localparam int INST_W  = 32;

  typedef struct packed {
    logic [FETCH_W-1:0]             vld;
    logic [FETCH_W-1:0][INST_W-1:0] inst;
  } fetch_bundle_t;

  // Number of set slot valids (0..8).
  function automatic logic [3:0] popcount8(input logic [FETCH_W-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Exclusive prefix count: how many valid slots sit below slot idx.
  function automatic logic [2:0] prefix8(input logic [FETCH_W-1:0] v, input int idx);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (i < idx) c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ace_instbuf_if.sv
// Fetch-side and decode-side signals of the decode-stage-0 instruction buffer.
// master = fetch/decode environment, slave = the buffer itself.
interface ace_instbuf_if #(
  parameter int DEPTH = 32,
  parameter int DEQ_W = 4
);
  import ace_fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              inst0_vld_d0_i;
  logic              inst1_vld_d0_i;
  logic              inst2_vld_d0_i;
  logic              inst3_vld_d0_i;
  logic              inst4_vld_d0_i;
  logic              inst5_vld_d0_i;
  logic              inst6_vld_d0_i;
  logic              inst7_vld_d0_i;
  logic [INST_W-1:0] inst0_d0_i;
  logic [INST_W-1:0] inst1_d0_i;
  logic [INST_W-1:0] inst2_d0_i;
  logic [INST_W-1:0] inst3_d0_i;
  logic [INST_W-1:0] inst4_d0_i;
  logic [INST_W-1:0] inst5_d0_i;
  logic [INST_W-1:0] inst6_d0_i;
  logic [INST_W-1:0] inst7_d0_i;
  logic              retire_flush_i;
  logic [2:0]        dec_accept_i;
  logic              decode_instbuf_full_o;
  logic [DEQ_W-1:0]  ib_vld_o;
  logic [INST_W-1:0] ib_inst0_o;
  logic [INST_W-1:0] ib_inst1_o;
  logic [INST_W-1:0] ib_inst2_o;
  logic [INST_W-1:0] ib_inst3_o;
  logic [CNT_W-1:0]  ib_count_o;

  modport master (
    output inst0_vld_d0_i, inst1_vld_d0_i, inst2_vld_d0_i, inst3_vld_d0_i,
           inst4_vld_d0_i, inst5_vld_d0_i, inst6_vld_d0_i, inst7_vld_d0_i,
           inst0_d0_i, inst1_d0_i, inst2_d0_i, inst3_d0_i,
           inst4_d0_i, inst5_d0_i, inst6_d0_i, inst7_d0_i,
           retire_flush_i, dec_accept_i,
    input  decode_instbuf_full_o, ib_vld_o,
           ib_inst0_o, ib_inst1_o, ib_inst2_o, ib_inst3_o, ib_count_o
  );

  modport slave (
    input  inst0_vld_d0_i, inst1_vld_d0_i, inst2_vld_d0_i, inst3_vld_d0_i,
           inst4_vld_d0_i, inst5_vld_d0_i, inst6_vld_d0_i, inst7_vld_d0_i,
           inst0_d0_i, inst1_d0_i, inst2_d0_i, inst3_d0_i,
           inst4_d0_i, inst5_d0_i, inst6_d0_i, inst7_d0_i,
           retire_flush_i, dec_accept_i,
    output decode_instbuf_full_o, ib_vld_o,
           ib_inst0_o, ib_inst1_o, ib_inst2_o, ib_inst3_o, ib_count_o
  );

endinterface

// File: rtl/ace_instbuf_pack.sv
// Combinational compactor: maps each of the 8 fetch slots to its write
// offset from the tail (number of valid slots below it) and counts the
// slots being enqueued.
module ace_instbuf_pack
  import ace_fetch_pkg::*;
(
  input  logic [FETCH_W-1:0]      vld,
  output logic [FETCH_W-1:0][2:0] offs,
  output logic [3:0]              enq_cnt
);

  // Prefix counts give each valid slot a dense position; invalid slots get
  // an offset too but are never written.
  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      offs[i] = prefix8(vld, i);
    end
    enq_cnt = popcount8(vld);
  end

endmodule

// File: rtl/ace_instbuf.sv
// Decode-stage-0 instruction buffer: compacts the valid slots of each fresh
// fetch bundle into a circular buffer, offers the oldest DEQ_W entries to
// decode, and back-pressures fetch while keeping a 16-entry reserve for the
// bundles already in flight. The instruction outputs are four wide.
module ace_instbuf
  import ace_fetch_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int DEQ_W = 4
) (
  input logic          clock,
  input logic          reset,
  ace_instbuf_if.slave ib
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int OCC_W   = CNT_W + 1;
  localparam int RESERVE = 16;

  fetch_bundle_t             bundle_d0;
  logic [FETCH_W-1:0]        acc_vld;
  logic [FETCH_W-1:0][2:0]   slot_off;
  logic [3:0]                enq_cnt;
  logic                      accept;
  logic                      fill_q;
  logic [PTR_W-1:0]          head_q;
  logic [PTR_W-1:0]          tail_q;
  logic [CNT_W-1:0]          count_q;
  logic [OCC_W-1:0]          occ_after_enq;
  logic [CNT_W-1:0]          deq_max;
  logic [PTR_W-1:0]          wr_ptr [FETCH_W];
  logic [INST_W-1:0]         mem [DEPTH];
  logic [DEQ_W-1:0]          offer_vld;
  logic [INST_W-1:0]         rd_inst [DEQ_W];

  assign bundle_d0.vld = {ib.inst7_vld_d0_i, ib.inst6_vld_d0_i,
                          ib.inst5_vld_d0_i, ib.inst4_vld_d0_i,
                          ib.inst3_vld_d0_i, ib.inst2_vld_d0_i,
                          ib.inst1_vld_d0_i, ib.inst0_vld_d0_i};
  assign bundle_d0.inst[0] = ib.inst0_d0_i;
  assign bundle_d0.inst[1] = ib.inst1_d0_i;
  assign bundle_d0.inst[2] = ib.inst2_d0_i;
  assign bundle_d0.inst[3] = ib.inst3_d0_i;
  assign bundle_d0.inst[4] = ib.inst4_d0_i;
  assign bundle_d0.inst[5] = ib.inst5_d0_i;
  assign bundle_d0.inst[6] = ib.inst6_d0_i;
  assign bundle_d0.inst[7] = ib.inst7_d0_i;

  // fill_q marks a bundle fetch has just advanced; a bundle held during a
  // stall sees fill_q=0 and is not enqueued a second time.
  assign accept  = fill_q & ~ib.retire_flush_i;
  assign acc_vld = accept ? bundle_d0.vld : '0;

  ace_instbuf_pack u_pack (
    .vld     (acc_vld),
    .offs    (slot_off),
    .enq_cnt (enq_cnt)
  );

  // Free space after this cycle's enqueue must cover the next two bundles;
  // dequeues are deliberately not credited until they are registered.
  assign occ_after_enq = {1'b0, count_q} + OCC_W'(enq_cnt);
  assign ib.decode_instbuf_full_o = reset | (occ_after_enq > OCC_W'(DEPTH - RESERVE));

  // Write address of each slot: tail plus its compacted position.
  always_comb begin
    for (int k = 0; k < FETCH_W; k++) begin
      wr_ptr[k] = tail_q + PTR_W'(slot_off[k]);
    end
  end

  // Entry storage: up to 8 writes per cycle, contents not reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (acc_vld[k]) mem[wr_ptr[k]] <= bundle_d0.inst[k];
    end
  end

  // Pointers, occupancy and fill flag; flush wins over enqueue and dequeue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      fill_q <= ~ib.decode_instbuf_full_o;
      if (ib.retire_flush_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_q + PTR_W'(ib.dec_accept_i);
        tail_q  <= tail_q + PTR_W'(enq_cnt);
        count_q <= count_q + CNT_W'(enq_cnt) - CNT_W'(ib.dec_accept_i);
      end
    end
  end

  // Offer the oldest entries straight from registered state; slots beyond
  // the occupancy (and everything during a flush) read as invalid and zero.
  always_comb begin
    for (int i = 0; i < DEQ_W; i++) begin
      offer_vld[i] = ~ib.retire_flush_i & (count_q > CNT_W'(i));
      rd_inst[i]   = offer_vld[i] ? mem[head_q + PTR_W'(i)] : '0;
    end
  end

  assign ib.ib_vld_o   = offer_vld;
  assign ib.ib_inst0_o = rd_inst[0];
  assign ib.ib_inst1_o = rd_inst[1];
  assign ib.ib_inst2_o = rd_inst[2];
  assign ib.ib_inst3_o = rd_inst[3];
  assign ib.ib_count_o = count_q;

  assign deq_max = (count_q < CNT_W'(DEQ_W)) ? count_q : CNT_W'(DEQ_W);

  // Protocol checks: decode never takes more than it was offered, and the
  // reserve keeps the buffer from overflowing.
  always @(posedge clock) begin
    if (!reset) begin
      a_accept_legal: assert (ib.retire_flush_i || (CNT_W'(ib.dec_accept_i) <= deq_max));
      a_no_overflow:  assert (count_q <= CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_ace_instbuf.sv
// Bench for ace_instbuf: directed steps plus randomized streams, checked
// against a queue-based model of the buffer contents and fill handshake.
module tb_ace_instbuf;
  import ace_fetch_pkg::*;

  localparam int DEPTH = 32;
  localparam int DEQ_W = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  b_vld;
  logic [31:0] b_inst [8];
  logic [31:0] obs_inst [4];

  always #5 clock = ~clock;

  ace_instbuf_if #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) ib ();

  ace_instbuf #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) dut (
    .clock (clock),
    .reset (reset),
    .ib    (ib)
  );

  assign ib.inst0_vld_d0_i = b_vld[0];
  assign ib.inst1_vld_d0_i = b_vld[1];
  assign ib.inst2_vld_d0_i = b_vld[2];
  assign ib.inst3_vld_d0_i = b_vld[3];
  assign ib.inst4_vld_d0_i = b_vld[4];
  assign ib.inst5_vld_d0_i = b_vld[5];
  assign ib.inst6_vld_d0_i = b_vld[6];
  assign ib.inst7_vld_d0_i = b_vld[7];
  assign ib.inst0_d0_i = b_inst[0];
  assign ib.inst1_d0_i = b_inst[1];
  assign ib.inst2_d0_i = b_inst[2];
  assign ib.inst3_d0_i = b_inst[3];
  assign ib.inst4_d0_i = b_inst[4];
  assign ib.inst5_d0_i = b_inst[5];
  assign ib.inst6_d0_i = b_inst[6];
  assign ib.inst7_d0_i = b_inst[7];
  assign obs_inst[0] = ib.ib_inst0_o;
  assign obs_inst[1] = ib.ib_inst1_o;
  assign obs_inst[2] = ib.ib_inst2_o;
  assign obs_inst[3] = ib.ib_inst3_o;

  // Reference model: buffer contents oldest-first, plus the fill flag.
  logic [31:0] q [$];
  bit          fill_m;
  bit          cur_acc_b;
  bit          cur_full;
  bit          cur_flush;
  int          cur_acc;
  bit          last_acc;
  bit          track_seq;
  logic [31:0] exp_out;
  logic [31:0] seq;
  int          n_pass;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mn4(input int s);
    return (s < DEQ_W) ? s : DEQ_W;
  endfunction

  // Apply controls, predict outputs, and compare mid-cycle.
  task automatic half_check(input bit flush, input int acc);
    int         enq;
    logic [3:0] ev;
    ib.retire_flush_i = flush;
    ib.dec_accept_i   = 3'(acc);
    cur_flush = flush;
    cur_acc   = acc;
    cur_acc_b = fill_m && !flush;
    enq       = cur_acc_b ? $countones(b_vld) : 0;
    cur_full  = (DEPTH - q.size() - enq) < 16;
    @(negedge clock);
    chk("count", 32'(ib.ib_count_o), 32'(q.size()));
    chk("full", 32'(ib.decode_instbuf_full_o), 32'(cur_full));
    ev = '0;
    for (int i = 0; i < 4; i++) if (!flush && q.size() > i) ev[i] = 1'b1;
    chk("vld", 32'(ib.ib_vld_o), 32'(ev));
    for (int i = 0; i < 4; i++) if (ev[i]) chk($sformatf("inst%0d", i), obs_inst[i], q[i]);
    if (track_seq && !flush) begin
      for (int i = 0; i < acc; i++) begin
        chk("seq", obs_inst[i], exp_out);
        exp_out++;
      end
    end
  endtask

  // Clock edge: advance the model by the rules of the buffer.
  task automatic commit();
    @(posedge clock);
    if (cur_flush) q.delete();
    else begin
      for (int i = 0; i < cur_acc; i++) void'(q.pop_front());
      if (cur_acc_b) for (int j = 0; j < 8; j++) if (b_vld[j]) q.push_back(b_inst[j]);
    end
    fill_m   = !cur_full;
    last_acc = cur_acc_b && (b_vld != 8'h00);
    #1;
  endtask

  task automatic cycle(input bit flush, input int acc);
    half_check(flush, acc);
    commit();
  endtask

  task automatic set_bundle(input logic [7:0] m, input logic [31:0] base);
    int n;
    n = 0;
    b_vld = m;
    for (int j = 0; j < 8; j++) begin
      b_inst[j] = m[j] ? base + 32'(n) : 32'hBAD0_0000 + 32'(j);
      if (m[j]) n++;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    b_vld = '0;
    while (q.size() > 0 && g < 100) begin
      cycle(1'b0, mn4(q.size()));
      g++;
    end
    chk("drain_count", 32'(ib.ib_count_o), 32'd0);
  endtask

  task automatic wait_fill();
    int g;
    g = 0;
    while (!fill_m && g < 10) begin
      cycle(1'b0, 0);
      g++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int a;
    logic [31:0] last;
    logic [7:0]  m;
    n_pass = 0; n_checks = 0; n_fail = 0;
    track_seq = 0; exp_out = '0; seq = '0; last_acc = 0;
    b_vld = '0;
    for (int j = 0; j < 8; j++) b_inst[j] = '0;
    ib.retire_flush_i = 1'b0;
    ib.dec_accept_i   = '0;
    reset = 1'b1;

    // Reset state.
    @(negedge clock);
    chk("rst_count", 32'(ib.ib_count_o), 32'd0);
    chk("rst_vld", 32'(ib.ib_vld_o), 32'd0);
    chk("rst_inst0", obs_inst[0], 32'd0);
    chk("rst_inst3", obs_inst[3], 32'd0);
    chk("rst_full", 32'(ib.decode_instbuf_full_o), 32'd1);
    @(posedge clock);
    #2 reset = 1'b0;
    q.delete();
    fill_m = 0;

    // Single full bundle after reset.
    cycle(1'b0, 0);
    set_bundle(8'hFF, 32'h100);
    cycle(1'b0, 0);
    b_vld = '0;
    half_check(1'b0, 0);
    chk("single_count", 32'(ib.ib_count_o), 32'd8);
    chk("single_vld", 32'(ib.ib_vld_o), 32'hF);
    chk("single_inst0", obs_inst[0], 32'h100);
    commit();
    drain();

    // Sparse mask compaction.
    wait_fill();
    b_vld = 8'b1010_0110;
    for (int j = 0; j < 8; j++) b_inst[j] = 32'hA0 + 32'(j);
    cycle(1'b0, 0);
    b_vld = '0;
    half_check(1'b0, 0);
    chk("sparse_count", 32'(ib.ib_count_o), 32'd4);
    chk("sparse_e0", obs_inst[0], 32'hA1);
    chk("sparse_e1", obs_inst[1], 32'hA2);
    chk("sparse_e2", obs_inst[2], 32'hA5);
    chk("sparse_e3", obs_inst[3], 32'hA7);
    commit();
    drain();

    // Held bundle: fetch advances only when a bundle is taken.
    wait_fill();
    seq = 32'h200; exp_out = 32'h200; track_seq = 1;
    set_bundle(8'hFF, seq);
    for (int c = 0; c < 6; c++) begin
      half_check(1'b0, 0);
      chk("held_le_depth", 32'(ib.ib_count_o <= DEPTH), 32'd1);
      commit();
      if (last_acc) begin seq += 8; set_bundle(8'hFF, seq); end
    end
    half_check(1'b0, 0);
    chk("held_count", 32'(ib.ib_count_o), 32'd24);
    chk("held_full", 32'(ib.decode_instbuf_full_o), 32'd1);
    commit();
    g = 0;
    while ((q.size() > 0 || b_vld != 8'h00) && g < 200) begin
      a = (q.size() == 0) ? 0 : $urandom_range(1, mn4(q.size()));
      half_check(1'b0, a);
      commit();
      if (last_acc) begin
        seq += 8;
        if (seq < 32'h240) set_bundle(8'hFF, seq);
        else b_vld = '0;
      end
      g++;
    end
    track_seq = 0;
    chk("held_stream_len", exp_out, 32'h240);

    // Wrap: 200 sequential instructions, random masks and accepts.
    seq = 32'h1000; exp_out = seq; last = 32'h1000 + 32'd200; track_seq = 1;
    m = 8'($urandom_range(1, 255));
    set_bundle(m, seq);
    g = 0;
    while ((seq < last || q.size() > 0) && g < 3000) begin
      a = $urandom_range(0, mn4(q.size()));
      half_check(1'b0, a);
      commit();
      if (last_acc) begin
        seq += 32'($countones(b_vld));
        if (seq < last) begin
          m = 8'($urandom_range(1, 255));
          while (32'($countones(m)) > last - seq) m = m & (m - 8'd1);
          set_bundle(m, seq);
        end else b_vld = '0;
      end
      g++;
    end
    track_seq = 0;
    chk("wrap_stream_len", exp_out, last);
    chk("wrap_empty", 32'(ib.ib_count_o), 32'd0);

    // Flush at count 20 with accept and a valid bundle.
    wait_fill();
    seq = 32'h300;
    set_bundle(8'h3C, seq);
    g = 0;
    while (q.size() < 20 && g < 20) begin
      cycle(1'b0, 0);
      if (last_acc) begin seq += 4; set_bundle(8'h3C, seq); end
      g++;
    end
    chk("flush_pre_count", 32'(ib.ib_count_o), 32'd20);
    set_bundle(8'hFF, 32'hDEAD_0000);
    half_check(1'b1, 4);
    commit();
    b_vld = '0;
    half_check(1'b0, 0);
    chk("flush_count", 32'(ib.ib_count_o), 32'd0);
    chk("flush_vld", 32'(ib.ib_vld_o), 32'd0);
    commit();
    cycle(1'b0, 0);
    cycle(1'b0, 0);

    // Flush while a fresh bundle would otherwise be taken.
    wait_fill();
    set_bundle(8'h07, 32'hEE00);
    cycle(1'b1, 0);
    b_vld = '0;
    cycle(1'b0, 0);
    chk("flush2_count", 32'(ib.ib_count_o), 32'd0);

    // Partial drain with simultaneous enqueue.
    wait_fill();
    set_bundle(8'h07, 32'hC0);
    cycle(1'b0, 0);
    set_bundle(8'h03, 32'hD0);
    cycle(1'b0, 3);
    b_vld = '0;
    half_check(1'b0, 0);
    chk("pdrain_count", 32'(ib.ib_count_o), 32'd2);
    chk("pdrain_inst0", obs_inst[0], 32'hD0);
    chk("pdrain_inst1", obs_inst[1], 32'hD1);
    commit();

    // Asynchronous reset with data in the buffer.
    set_bundle(8'hFF, 32'h500);
    wait_fill();
    cycle(1'b0, 0);
    b_vld = '0;
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 32'(ib.ib_count_o), 32'd0);
    chk("arst_vld", 32'(ib.ib_vld_o), 32'd0);
    chk("arst_full", 32'(ib.decode_instbuf_full_o), 32'd1);
    @(posedge clock);
    #2 reset = 1'b0;
    q.delete();
    fill_m = 0;
    cycle(1'b0, 0);
    cycle(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
